// File: rtl/aes_pkg.sv
// Shared AES constants and sequencer state encodings for the encrypt and
// decrypt control paths.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_W  = 128;
   localparam int RND_W  = 4;

   localparam logic [RND_W-1:0] LAST_ROUND = AES_NR[RND_W-1:0];

   // Forward cipher sequencer states
   localparam logic [2:0] ENC_IDLE_C  = 3'd0;
   localparam logic [2:0] ENC_ADD_C   = 3'd1;
   localparam logic [2:0] ENC_SUB_C   = 3'd2;
   localparam logic [2:0] ENC_SHIFT_C = 3'd3;
   localparam logic [2:0] ENC_MIX_C   = 3'd4;
   localparam logic [2:0] ENC_DONE_C  = 3'd5;

   typedef enum logic [2:0] {
      ENC_IDLE  = ENC_IDLE_C,
      ENC_ADD   = ENC_ADD_C,
      ENC_SUB   = ENC_SUB_C,
      ENC_SHIFT = ENC_SHIFT_C,
      ENC_MIX   = ENC_MIX_C,
      ENC_DONE  = ENC_DONE_C
   } enc_state_e;

   // Inverse cipher sequencer states
   localparam logic [2:0] DEC_IDLE_C      = 3'd0;
   localparam logic [2:0] DEC_ADD_C       = 3'd1;
   localparam logic [2:0] DEC_INV_SUB_C   = 3'd2;
   localparam logic [2:0] DEC_INV_SHIFT_C = 3'd3;
   localparam logic [2:0] DEC_INV_MIX_C   = 3'd4;
   localparam logic [2:0] DEC_DONE_C      = 3'd5;

   typedef enum logic [2:0] {
      DEC_IDLE      = DEC_IDLE_C,
      DEC_ADD       = DEC_ADD_C,
      DEC_INV_SUB   = DEC_INV_SUB_C,
      DEC_INV_SHIFT = DEC_INV_SHIFT_C,
      DEC_INV_MIX   = DEC_INV_MIX_C,
      DEC_DONE      = DEC_DONE_C
   } dec_state_e;

   // One-hot stage enables {mix, shift, sub, add} decoded from the state.
   function automatic logic [3:0] enc_stage_en(input enc_state_e s);
      logic [3:0] en;
      en = 4'b0000;
      case (s)
         ENC_ADD:   en = 4'b0001;
         ENC_SUB:   en = 4'b0010;
         ENC_SHIFT: en = 4'b0100;
         ENC_MIX:   en = 4'b1000;
         default:   en = 4'b0000;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/aes_encrypt_sequencer.sv
// AES-128 forward cipher control: walks the AddRoundKey/SubBytes/ShiftRows/
// MixColumns stages through 10 rounds and holds the running state word.
module aes_encrypt_sequencer
   import aes_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic [AES_W-1:0] PT,
   output logic [RND_W-1:0] SelKey,
   output logic             Ry,
   output logic [AES_W-1:0] CT,
   output logic             AddEn,
   output logic             SubEn,
   output logic             ShiftEn,
   output logic             MixEn,
   input  logic             AddRy,
   input  logic             SubRy,
   input  logic             ShiftRy,
   input  logic             MixRy,
   output logic [AES_W-1:0] Text,
   input  logic [AES_W-1:0] AddText,
   input  logic [AES_W-1:0] SubText,
   input  logic [AES_W-1:0] ShiftText,
   input  logic [AES_W-1:0] MixText
);

   enc_state_e       state_q, state_d;
   logic [RND_W-1:0] round_q, round_d;
   logic [AES_W-1:0] text_q,  text_d;
   logic [AES_W-1:0] ct_q,    ct_d;
   logic             ry_q,    ry_d;
   logic             first_q, first_d;

   logic             stage_ry;
   logic [AES_W-1:0] stage_res;
   logic             stage_done;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ENC_IDLE;
         round_q <= '0;
         text_q  <= '0;
         ct_q    <= '0;
         ry_q    <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         text_q  <= text_d;
         ct_q    <= ct_d;
         ry_q    <= ry_d;
         first_q <= first_d;
      end
   end

   // Only the active stage's ready/result are looked at; the rest are ignored.
   always_comb begin
      stage_ry  = 1'b0;
      stage_res = text_q;
      case (state_q)
         ENC_ADD:   begin stage_ry = AddRy;   stage_res = AddText;   end
         ENC_SUB:   begin stage_ry = SubRy;   stage_res = SubText;   end
         ENC_SHIFT: begin stage_ry = ShiftRy; stage_res = ShiftText; end
         ENC_MIX:   begin stage_ry = MixRy;   stage_res = MixText;   end
         default:   begin stage_ry = 1'b0;    stage_res = text_q;    end
      endcase
   end

   // first_q masks the entry cycle so a ready left over from a prior use
   // cannot complete the new stage.
   assign stage_done = stage_ry && !first_q;

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      text_d  = text_q;
      ct_d    = ct_q;
      ry_d    = ry_q;
      first_d = 1'b0;
      case (state_q)
         ENC_IDLE: begin
            if (En) begin
               text_d  = PT;
               round_d = '0;
               first_d = 1'b1;
               state_d = ENC_ADD;
            end
         end
         ENC_ADD: begin
            if (stage_done) begin
               text_d  = stage_res;
               first_d = 1'b1;
               if (round_q == LAST_ROUND) begin
                  ct_d    = stage_res;
                  ry_d    = 1'b1;
                  state_d = ENC_DONE;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = ENC_SUB;
               end
            end
         end
         ENC_SUB: begin
            if (stage_done) begin
               text_d  = stage_res;
               first_d = 1'b1;
               state_d = ENC_SHIFT;
            end
         end
         ENC_SHIFT: begin
            if (stage_done) begin
               text_d  = stage_res;
               first_d = 1'b1;
               // The final round skips MixColumns.
               state_d = (round_q == LAST_ROUND) ? ENC_ADD : ENC_MIX;
            end
         end
         ENC_MIX: begin
            if (stage_done) begin
               text_d  = stage_res;
               first_d = 1'b1;
               state_d = ENC_ADD;
            end
         end
         ENC_DONE: begin
            if (!En) begin
               ry_d    = 1'b0;
               state_d = ENC_IDLE;
            end
         end
         default: begin
            state_d = ENC_IDLE;
         end
      endcase
   end

   assign {MixEn, ShiftEn, SubEn, AddEn} = enc_stage_en(state_q);
   assign SelKey = round_q;
   assign Ry     = ry_q;
   assign CT     = ct_q;
   assign Text   = text_q;

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Directed bench for aes_encrypt_sequencer using behavioural stub stages
// with simple, reversible-looking transforms and controllable ready timing.
module tb_aes_encrypt_sequencer;
   import aes_pkg::*;

   localparam logic [127:0] MIXC = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;

   logic         Clk = 1'b0;
   logic         Rst, En;
   logic [127:0] PT;
   logic [3:0]   SelKey;
   logic         Ry;
   logic [127:0] CT, Text;
   logic         AddEn, SubEn, ShiftEn, MixEn;
   logic         AddRy, SubRy, ShiftRy, MixRy;
   logic [127:0] AddText, SubText, ShiftText, MixText;

   logic stray = 1'b0;
   logic stall = 1'b0;
   logic mon_clr = 1'b0;
   int   sub_cnt = 0;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   aes_encrypt_sequencer dut (
      .Clk(Clk), .Rst(Rst), .En(En), .PT(PT), .SelKey(SelKey), .Ry(Ry), .CT(CT),
      .AddEn(AddEn), .SubEn(SubEn), .ShiftEn(ShiftEn), .MixEn(MixEn),
      .AddRy(AddRy), .SubRy(SubRy), .ShiftRy(ShiftRy), .MixRy(MixRy),
      .Text(Text), .AddText(AddText), .SubText(SubText), .ShiftText(ShiftText),
      .MixText(MixText)
   );

   // Stub stages
   always @(posedge Clk) sub_cnt <= SubEn ? sub_cnt + 1 : 0;
   assign AddRy   = stray | AddEn;
   assign ShiftRy = stray | ShiftEn;
   assign MixRy   = stray | MixEn;
   assign SubRy   = stray | (SubEn && (sub_cnt >= ((stall && SelKey == 4'd3) ? 6 : 0)));
   assign AddText   = Text ^ {32{SelKey}};
   assign SubText   = Text + 128'd1;
   assign ShiftText = {Text[119:0], Text[127:120]};
   assign MixText   = Text ^ MIXC;

   // Monitor
   int add_stg = 0, sub_stg = 0, shf_stg = 0, mix_stg = 0;
   int add_cyc = 0, sub_cyc = 0, shf_cyc = 0, mix_cyc = 0;
   int mix10 = 0, key_viol = 0, stage_viol = 0;
   logic [3:0]   p_en = 4'b0000;
   logic [3:0]   p_key = 4'd0;
   logic [127:0] p_text = '0;
   wire  [3:0]   cur_en = {MixEn, ShiftEn, SubEn, AddEn};

   always @(negedge Clk) begin
      if (mon_clr) begin
         add_stg <= 0; sub_stg <= 0; shf_stg <= 0; mix_stg <= 0;
         add_cyc <= 0; sub_cyc <= 0; shf_cyc <= 0; mix_cyc <= 0;
         mix10 <= 0; key_viol <= 0; stage_viol <= 0;
      end else begin
         if (AddEn   && !p_en[0]) add_stg <= add_stg + 1;
         if (SubEn   && !p_en[1]) sub_stg <= sub_stg + 1;
         if (ShiftEn && !p_en[2]) shf_stg <= shf_stg + 1;
         if (MixEn   && !p_en[3]) mix_stg <= mix_stg + 1;
         if (AddEn)   add_cyc <= add_cyc + 1;
         if (SubEn)   sub_cyc <= sub_cyc + 1;
         if (ShiftEn) shf_cyc <= shf_cyc + 1;
         if (MixEn)   mix_cyc <= mix_cyc + 1;
         if (MixEn && SelKey == 4'd10) mix10 <= mix10 + 1;
         if (p_en != 4'b0000 && SelKey != p_key &&
             !(p_en[0] && SubEn && SelKey == p_key + 4'd1))
            key_viol <= key_viol + 1;
         if ((cur_en & p_en) != 4'b0000 && (Text != p_text || SelKey != p_key))
            stage_viol <= stage_viol + 1;
      end
      p_en   <= cur_en;
      p_key  <= SelKey;
      p_text <= Text;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] pt);
      logic [127:0] s;
      logic [3:0]   k;
      s = pt;
      for (int r = 1; r <= 10; r++) begin
         k = 4'(r);
         s = s + 128'd1;
         s = {s[119:0], s[127:120]};
         if (r < 10) s = s ^ MIXC;
         s = s ^ {32{k}};
      end
      return s;
   endfunction

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge Clk); #1;
      mon_clr = 1'b0;
   endtask

   task automatic go_idle();
      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic run(input logic [127:0] pt, input bit chk_start, output int lat);
      @(negedge Clk);
      En = 1'b1;
      PT = pt;
      @(posedge Clk); #1;
      if (chk_start) begin
         chk("start_add_en", 128'(AddEn), 128'd1);
         chk("start_text", Text, pt);
         chk("start_selkey", 128'(SelKey), 128'd0);
      end
      lat = 0;
      while (Ry !== 1'b1 && lat < 400) begin
         @(posedge Clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int n;
      logic [127:0] pt;
      logic [127:0] exp_ct;

      Rst = 1'b1; En = 1'b0; PT = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_selkey", 128'(SelKey), 128'd0);
      chk("rst_ry", 128'(Ry), 128'd0);
      chk("rst_ct", CT, 128'd0);
      chk("rst_text", Text, 128'd0);
      chk("rst_en", 128'(cur_en), 128'd0);
      Rst = 1'b0;

      // Stray readies in IDLE must not start anything
      stray = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      chk("idle_stray_en", 128'(cur_en), 128'd0);
      stray = 1'b0;

      // Nominal run
      pt = 128'h00112233_44556677_8899aabb_ccddeeff;
      exp_ct = model(pt);
      clear_mon();
      run(pt, 1'b1, lat);
      chk("lat_nominal", 128'(lat), 128'd80);
      chk("ct_nominal", CT, exp_ct);
      chk("done_selkey", 128'(SelKey), 128'd10);
      chk("done_en", 128'(cur_en), 128'd0);
      chk("add_stages", 128'(add_stg), 128'd11);
      chk("sub_stages", 128'(sub_stg), 128'd10);
      chk("shift_stages", 128'(shf_stg), 128'd10);
      chk("mix_stages", 128'(mix_stg), 128'd9);
      chk("add_cycles", 128'(add_cyc), 128'd22);
      chk("sub_cycles", 128'(sub_cyc), 128'd20);
      chk("shift_cycles", 128'(shf_cyc), 128'd20);
      chk("mix_cycles", 128'(mix_cyc), 128'd18);
      chk("mix_in_r10", 128'(mix10), 128'd0);
      chk("selkey_seq", 128'(key_viol), 128'd0);

      // DONE holds while En stays high
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk); #1;
         chk("hold_ry", 128'(Ry), 128'd1);
         chk("hold_ct", CT, exp_ct);
      end
      go_idle();
      chk("drop_ry", 128'(Ry), 128'd0);
      chk("drop_en", 128'(cur_en), 128'd0);

      // SubBytes stall in round 3
      pt = 128'hdeadbeef_01234567_89abcdef_fedcba98;
      clear_mon();
      stall = 1'b1;
      run(pt, 1'b1, lat);
      stall = 1'b0;
      chk("lat_stall", 128'(lat), 128'd85);
      chk("ct_stall", CT, model(pt));
      chk("stall_stable", 128'(stage_viol), 128'd0);
      chk("stall_selkey_seq", 128'(key_viol), 128'd0);
      go_idle();

      // Readies held high everywhere: stale ready masking
      stray = 1'b1;
      pt = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
      clear_mon();
      run(pt, 1'b0, lat);
      chk("lat_stale", 128'(lat), 128'd80);
      chk("ct_stale", CT, model(pt));
      chk("stale_add_cycles", 128'(add_cyc), 128'd22);
      chk("stale_mix_cycles", 128'(mix_cyc), 128'd18);
      go_idle();
      repeat (3) @(posedge Clk);
      #1;
      chk("stale_idle_en", 128'(cur_en), 128'd0);
      stray = 1'b0;

      // Reset in round 5
      @(negedge Clk);
      En = 1'b1;
      PT = 128'h11111111_22222222_33333333_44444444;
      n = 0;
      @(posedge Clk); #1;
      while (SelKey !== 4'd5 && n < 200) begin
         @(posedge Clk); #1;
         n++;
      end
      chk("reach_round5", 128'(SelKey), 128'd5);
      Rst = 1'b1;
      En  = 1'b0;
      @(posedge Clk); #1;
      chk("mid_rst_selkey", 128'(SelKey), 128'd0);
      chk("mid_rst_ry", 128'(Ry), 128'd0);
      chk("mid_rst_ct", CT, 128'd0);
      chk("mid_rst_text", Text, 128'd0);
      chk("mid_rst_en", 128'(cur_en), 128'd0);
      Rst = 1'b0;
      @(posedge Clk); #1;
      chk("post_rst_idle", 128'(cur_en), 128'd0);
      clear_mon();
      run(128'd0, 1'b1, lat);
      chk("lat_after_rst", 128'(lat), 128'd80);
      chk("ct_zero_pt", CT, model(128'd0));
      chk("after_rst_selkey_seq", 128'(key_viol), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
